// File: rtl/apb4_crc_feeder_pkg.sv
// Shared definitions for the APB4 CRC feeder: FSM state codes, CRC
// peripheral register map, mode encodings and the result width mask.
package crc_feeder_pkg;

    // Feeder FSM state codes
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_COLLECT = 4'd1;
    localparam state_t ST_WR_CTRL = 4'd2;
    localparam state_t ST_WR_INIT = 4'd3;
    localparam state_t ST_WR_XORV = 4'd4;
    localparam state_t ST_WR_DATA = 4'd5;
    localparam state_t ST_RD_STAT = 4'd6;
    localparam state_t ST_RD_DATA = 4'd7;
    localparam state_t ST_RESULT  = 4'd8;

    // CRC peripheral register indices (byte offset = index * 4)
    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_INIT = 3'd1;
    localparam logic [2:0] REG_XORV = 3'd2;
    localparam logic [2:0] REG_DATA = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;

    // CRC mode encodings as seen in CTRL.mode
    localparam logic [1:0] MODE_CRC8       = 2'd0;
    localparam logic [1:0] MODE_CRC16_1021 = 2'd1;
    localparam logic [1:0] MODE_CRC16_8005 = 2'd2;
    localparam logic [1:0] MODE_CRC32      = 2'd3;

    // Byte offset of a register index
    function automatic logic [31:0] reg_offset(input logic [2:0] idx);
        return {27'd0, idx, 2'b00};
    endfunction

    // Bits of a DATA read that carry the CRC for the given mode
    function automatic logic [31:0] width_mask(input logic [1:0] mode);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        case (mode)
            MODE_CRC8:       m = 32'h0000_00FF;
            MODE_CRC16_1021: m = 32'h0000_FFFF;
            MODE_CRC16_8005: m = 32'h0000_FFFF;
            MODE_CRC32:      m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/apb4_master_port.sv
// Single-access APB4 master. A request is taken whenever the port is idle;
// o_ack pulses in the access cycle that sees pready, with o_rdata/o_err
// passed straight from the bus in that same cycle.
module apb4_master_port (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_paddr,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_pwdata,
    input  logic [31:0] i_prdata,
    input  logic        i_pready,
    input  logic        i_pslverr
);

    logic        r_psel;
    logic        r_penable;
    logic [31:0] r_paddr;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic        w_done;

    assign w_done = r_psel & r_penable & i_pready;

    // Setup -> access -> idle sequencing; address/control latched at setup
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
        end else if (!r_psel) begin
            if (i_req) begin
                r_psel   <= 1'b1;
                r_paddr  <= i_addr;
                r_pwrite <= i_wr;
                r_pwdata <= i_wdata;
            end
        end else if (!r_penable) begin
            r_penable <= 1'b1;
        end else if (i_pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end
    end

    assign o_ack     = w_done;
    assign o_rdata   = i_prdata;
    assign o_err     = w_done & i_pslverr;
    assign o_paddr   = r_paddr;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/apb4_crc_feeder.sv
// APB4 master that streams bytes into the apb4_crc peripheral word by word,
// chaining raw intermediate CRCs through INIT, and returns the frame CRC on
// a valid/ready result port.
module apb4_crc_feeder
    import crc_feeder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          POLL_MAX  = 64
) (
    input  logic        apb4_pclk,
    input  logic        apb4_presetn,
    input  logic [1:0]  cfg_mode_i,
    input  logic        cfg_revin_i,
    input  logic        cfg_revout_i,
    input  logic [31:0] cfg_init_i,
    input  logic [31:0] cfg_xorv_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_crc_o,
    output logic        res_err_o,
    output logic        busy_o,
    output logic [31:0] m_paddr_o,
    output logic        m_psel_o,
    output logic        m_penable_o,
    output logic        m_pwrite_o,
    output logic [31:0] m_pwdata_o,
    input  logic [31:0] m_prdata_i,
    input  logic        m_pready_i,
    input  logic        m_pslverr_i
);

    localparam int             PW       = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0]  POLL_LIM = PW'(POLL_MAX);

    state_t        r_state;
    logic          r_s_ready;
    logic [31:0]   r_word;
    logic [2:0]    r_cnt;
    logic          r_last;
    logic          r_first;
    logic [1:0]    r_mode;
    logic          r_revin;
    logic          r_revout;
    logic [31:0]   r_init;
    logic [31:0]   r_xorv;
    logic [31:0]   r_prev_crc;
    logic [PW-1:0] r_poll;
    logic          r_err;
    logic [31:0]   r_res_crc;
    logic          r_res_valid;
    logic          r_busy;

    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_close;
    logic          w_req;
    logic [2:0]    w_reg;
    logic          w_wr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_addr;
    logic          w_ack;
    logic [31:0]   w_rdata;
    logic          w_err;
    logic [31:0]   w_masked;
    logic [1:0]    w_size;
    logic [PW-1:0] w_poll_inc;
    logic          w_poll_done;

    assign w_accept    = s_valid_i & r_s_ready;
    assign w_close     = s_last_i | (r_cnt == 3'd3);
    assign w_size      = r_cnt[1:0] - 2'd1;
    assign w_poll_inc  = r_poll + PW'(1);
    assign w_poll_done = (w_poll_inc == POLL_LIM);
    assign w_masked    = w_rdata & width_mask(r_mode);
    assign w_addr      = BASE_ADDR + reg_offset(w_reg);

    // Select the APB access the current state needs
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_req   = 1'b0;
        w_reg   = REG_CTRL;
        w_wr    = 1'b1;
        w_wdata = '0;
        case (r_state)
            ST_WR_CTRL: begin
                w_req   = 1'b1;
                w_wdata = {25'd0, w_size, r_mode, r_last & r_revout, r_revin, 1'b1};
            end
            ST_WR_INIT: begin
                w_req   = 1'b1;
                w_reg   = REG_INIT;
                w_wdata = r_first ? r_init : r_prev_crc;
            end
            ST_WR_XORV: begin
                w_req   = 1'b1;
                w_reg   = REG_XORV;
                w_wdata = r_last ? r_xorv : 32'd0;
            end
            ST_WR_DATA: begin
                w_req   = 1'b1;
                w_reg   = REG_DATA;
                w_wdata = r_word;
            end
            ST_RD_STAT: begin
                w_req = 1'b1;
                w_reg = REG_STAT;
                w_wr  = 1'b0;
            end
            ST_RD_DATA: begin
                w_req = 1'b1;
                w_reg = REG_DATA;
                w_wr  = 1'b0;
            end
            default: ;
        endcase
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_accept && w_close) w_state_nxt = ST_WR_CTRL;
                else if (w_accept)       w_state_nxt = ST_COLLECT;
            end
            ST_WR_CTRL: if (w_ack) w_state_nxt = ST_WR_INIT;
            ST_WR_INIT: if (w_ack) w_state_nxt = ST_WR_XORV;
            ST_WR_XORV: if (w_ack) w_state_nxt = ST_WR_DATA;
            ST_WR_DATA: if (w_ack) w_state_nxt = ST_RD_STAT;
            ST_RD_STAT: if (w_ack && (w_rdata[0] || w_poll_done)) w_state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (w_ack) w_state_nxt = r_last ? ST_RESULT : ST_COLLECT;
            ST_RESULT:  if (res_ready_i) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM, byte packer, frame config, CRC chaining and result registers
    always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
        if (!apb4_presetn) begin
            r_state     <= ST_IDLE;
            r_s_ready   <= 1'b0;
            r_word      <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_first     <= 1'b0;
            r_mode      <= '0;
            r_revin     <= 1'b0;
            r_revout    <= 1'b0;
            r_init      <= '0;
            r_xorv      <= '0;
            r_prev_crc  <= '0;
            r_poll      <= '0;
            r_err       <= 1'b0;
            r_res_crc   <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == ST_IDLE || w_state_nxt == ST_COLLECT);

            if (w_accept) begin
                r_word <= {r_word[23:0], s_data_i};
                r_cnt  <= r_cnt + 3'd1;
                if (w_close) r_last <= s_last_i;
                if (r_state == ST_IDLE) begin
                    r_mode   <= cfg_mode_i;
                    r_revin  <= cfg_revin_i;
                    r_revout <= cfg_revout_i;
                    r_init   <= cfg_init_i;
                    r_xorv   <= cfg_xorv_i;
                    r_first  <= 1'b1;
                    r_err    <= 1'b0;
                    r_busy   <= 1'b1;
                end
            end

            if (w_err) r_err <= 1'b1;

            case (r_state)
                ST_WR_DATA: if (w_ack) r_poll <= '0;
                ST_RD_STAT: begin
                    if (w_ack) begin
                        r_poll <= w_poll_inc;
                        if (!w_rdata[0] && w_poll_done) r_err <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (w_ack) begin
                        if (r_last) begin
                            r_res_crc   <= w_masked;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_prev_crc <= w_masked;
                            r_first    <= 1'b0;
                        end
                        r_word <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_RESULT: begin
                    if (res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_last      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    apb4_master_port u_port (
        .i_clk     (apb4_pclk),
        .i_rst_n   (apb4_presetn),
        .i_req     (w_req),
        .i_addr    (w_addr),
        .i_wr      (w_wr),
        .i_wdata   (w_wdata),
        .o_ack     (w_ack),
        .o_rdata   (w_rdata),
        .o_err     (w_err),
        .o_paddr   (m_paddr_o),
        .o_psel    (m_psel_o),
        .o_penable (m_penable_o),
        .o_pwrite  (m_pwrite_o),
        .o_pwdata  (m_pwdata_o),
        .i_prdata  (m_prdata_i),
        .i_pready  (m_pready_i),
        .i_pslverr (m_pslverr_i)
    );

    assign s_ready_o   = r_s_ready;
    assign res_valid_o = r_res_valid;
    assign res_crc_o   = r_res_crc;
    assign res_err_o   = r_err;
    assign busy_o      = r_busy;

endmodule

// File: doc/apb4_crc_feeder.md
Name: apb4_crc_feeder

Overview:
APB4 master that sits directly upstream of the apb4_crc peripheral and computes a CRC over a byte stream of any length.
- Accepts a valid/ready byte stream with a last flag and packs up to 4 bytes per word.
- For each word, programs CTRL/INIT/XORV, writes DATA, polls STAT, then reads back DATA.
- Chains words by feeding each intermediate raw CRC back as INIT.
- Presents the final CRC on a valid/ready result port, so software or a DMA gets whole-frame CRCs without driving the peripheral itself.

Parameters:
BASE_ADDR, 32'h0, APB base address of the CRC peripheral; registers at +0x00 CTRL, +0x04 INIT, +0x08 XORV, +0x0C DATA, +0x10 STAT
POLL_MAX, 64, maximum STAT reads per word before declaring a timeout (width = $clog2(POLL_MAX+1))

Ports:
apb4_pclk  in  1  clock
apb4_presetn  in  1  reset, asynchronous, active-low
cfg_mode_i  in  2  CRC mode (CRC8/CRC16_1021/CRC16_8005/CRC32 encodings)
cfg_revin_i  in  1  reflect input bytes
cfg_revout_i  in  1  reflect final result
cfg_init_i  in  32  initial CRC value
cfg_xorv_i  in  32  final XOR value
s_valid_i  in  1  byte valid
s_ready_o  out  1  byte accepted
s_data_i  in  8  byte
s_last_i  in  1  last byte of frame
res_valid_o  out  1  result valid
res_ready_i  in  1  result taken
res_crc_o  out  32  final CRC, zero-extended to mode width
res_err_o  out  1  frame saw PSLVERR or poll timeout
busy_o  out  1  frame in progress
m_paddr_o  out  32  APB address
m_psel_o  out  1  APB select
m_penable_o  out  1  APB enable
m_pwrite_o  out  1  APB write
m_pwdata_o  out  32  APB write data
m_prdata_i  in  32  APB read data
m_pready_i  in  1  APB ready
m_pslverr_i  in  1  APB error

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; packer, prev_crc, poll counter and error flag cleared. Reset mid-transfer drops psel immediately; the peripheral is re-programmed fully on the next frame.
- Config: cfg_* sampled on the first accepted byte of a frame, then held for the whole frame.
- States: IDLE, COLLECT, WR_CTRL, WR_INIT, WR_XORV, WR_DATA, RD_STAT, RD_DATA, RESULT.
- Byte intake:
  - s_ready_o=1 only in IDLE/COLLECT, and only while the packer holds fewer than 4 bytes.
  - A word closes on the 4th byte or on s_last_i; the FSM then goes to WR_CTRL.
- Packing, n = bytes in word (1..4):
  - pwdata[8n-1:0] holds the bytes, first byte at [8n-1:8n-8]; upper bits 0.
  - size field = n-1.
- Per-word programming:
  - CTRL = {size, mode, revout_eff, revin, en=1}; revout_eff = cfg_revout on the final word, else 0.
  - INIT = cfg_init for the first word, else prev_crc.
  - XORV = cfg_xorv on the final word, else 0.
- APB access: setup cycle (psel=1, penable=0), then access cycle(s) (penable=1) until pready. Zero-wait access = 2 cycles; m_paddr/m_pwrite/m_pwdata stable for the whole access.
- RD_STAT:
  - Repeat until prdata[0]=1; the read itself clears STAT.
  - Each read increments the poll counter.
  - Counter reaching POLL_MAX sets err and proceeds to RD_DATA.
- RD_DATA:
  - Mask prdata to mode width: CRC8 [7:0], CRC16 [15:0], CRC32 [31:0].
  - Intermediate word: store into prev_crc and return to COLLECT.
  - Final word: load into res_crc_o and go to RESULT.
- RESULT: res_valid_o=1, held stable until res_ready_i; then IDLE. No bytes are accepted meanwhile.
- PSLVERR on any access sets the frame error flag and the sequence continues. res_err_o is valid with res_valid_o and cleared when a new frame starts.
- busy_o=1 from the first accepted byte until the result handshake completes.
- Frame of 1 byte with last: single word, n=1.

Decomposition:
- Package crc_feeder_pkg holds:
  - FSM state enum;
  - register offset constants, matching crc_define (CTRL..STAT indices 0..4);
  - mode encodings;
  - width-mask function.
- Sub-module apb4_master_port: a single-access APB4 master handshake (req/ack, addr, wr, wdata, rdata, err) that the FSM drives.

Test Plan:
- CRC32, revin=1, revout=1, init FFFFFFFF, xorv FFFFFFFF, "123456789" (words of 4,4,1 bytes) -> res_crc_o=32'hCBF43926, res_err_o=0.
- CRC8 mode, revin/revout=0, init 0, xorv 0, "123456789" -> 32'h000000F4.
- CRC16_1021, init FFFF, xorv 0, no reflection, "123456789" -> 32'h000029B1; check intermediate INIT writes equal the previous raw reads.
- CRC16_8005, revin=revout=1, init 0, xorv 0, "123456789" -> 32'h0000BB3D. Hold res_ready_i low 10 cycles: res_valid/res_crc stable and s_ready_o=0.
- Slave with pready low 3 cycles and pslverr on the INIT write, single byte 0x00 CRC8 -> result still produced, res_err_o=1. A stuck STAT=0 model -> exactly POLL_MAX STAT reads, then err=1.
- Assert apb4_presetn low in the middle of WR_DATA -> psel/penable drop asynchronously, all outputs 0. The next frame "123456789" CRC32 -> CBF43926.
